// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Parametrised integer register file with NUM_RD combinational
//                read ports, one synchronous write port, optional same-cycle
//                write-to-read bypass and a per-register busy scoreboard used
//                by decode to stall on operands that are still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int register_count = 32,
    parameter int data_length    = 32,
    parameter int NUM_RD         = 2,
    parameter bit BYPASS_EN      = 1'b1,
    parameter bit ZERO_REG_EN    = 1'b1,
    localparam int AW            = $clog2(register_count)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_RD*AW-1:0]          r_addr_reg,
    output logic [NUM_RD*data_length-1:0] r_data_reg,
    output logic [NUM_RD-1:0]             r_valid_reg,
    input  logic                          w_ctrl_reg,
    input  logic [AW-1:0]                 w_addr_reg,
    input  logic [data_length-1:0]        w_data_reg,
    input  logic                          iss_ctrl,
    input  logic [AW-1:0]                 iss_addr,
    output logic [register_count-1:0]     busy_vec
);

    // ------------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------------
    logic [data_length-1:0]    mem_q [register_count];
    logic [data_length-1:0]    mem_d [register_count];
    logic [register_count-1:0] busy_q;
    logic [register_count-1:0] busy_d;

    // One-hot strobes selecting the register touched by writeback / issue.
    logic [register_count-1:0] wr_sel;
    logic [register_count-1:0] iss_sel;

    // Decode write and issue addresses; register 0 is masked when hardwired.
    always_comb begin
        wr_sel  = '0;
        iss_sel = '0;
        if (w_ctrl_reg) begin
            wr_sel[w_addr_reg] = 1'b1;
        end
        if (iss_ctrl) begin
            iss_sel[iss_addr] = 1'b1;
        end
        if (ZERO_REG_EN) begin
            wr_sel[0]  = 1'b0;
            iss_sel[0] = 1'b0;
        end
    end

    // Next-state: writeback retires a producer, a same-cycle issue re-arms it.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < register_count; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_sel[i]) begin
                mem_d[i]  = w_data_reg;
                busy_d[i] = 1'b0;
            end
            // Issue is applied last so the new producer wins over the retiring one.
            if (iss_sel[i]) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    // State registers; reset clears data and pending state without a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < register_count; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < register_count; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // ------------------------------------------------------------------------
    // Read ports: fully independent, any number may target the same register.
    // ------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [AW-1:0]          addr;
            logic                   hit;
            logic [data_length-1:0] data;
            logic                   valid;

            assign addr = r_addr_reg[k*AW +: AW];

            // Forward the in-flight writeback unless it targets a hardwired x0.
            assign hit = BYPASS_EN && w_ctrl_reg && (w_addr_reg == addr) &&
                         !(ZERO_REG_EN && (addr == '0));

            // Lane output; reset forces a clean zero/valid view regardless of bypass.
            always_comb begin
                data  = mem_q[addr];
                valid = !busy_q[addr];
                if (!rst) begin
                    data  = '0;
                    valid = 1'b1;
                end else if (hit) begin
                    data  = w_data_reg;
                    valid = 1'b1;
                end
            end

            assign r_data_reg[k*data_length +: data_length] = data;
            assign r_valid_reg[k]                           = valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Directed self-checking bench for regfile_sb. Two instances
//                share inputs: u_dut uses defaults (bypass on, x0 hardwired),
//                u_nb has bypass off and x0 as an ordinary register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int AW = 5;
    localparam int DL = 32;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*AW-1:0] r_addr;
    logic [NR*DL-1:0] rd_a;
    logic [NR*DL-1:0] rd_b;
    logic [NR-1:0]    rv_a;
    logic [NR-1:0]    rv_b;
    logic             w_ctrl;
    logic [AW-1:0]    w_addr;
    logic [DL-1:0]    w_data;
    logic             iss_ctrl;
    logic [AW-1:0]    iss_addr;
    logic [31:0]      busy_a;
    logic [31:0]      busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_sb u_dut (
        .clk         (clk),
        .rst         (rst),
        .r_addr_reg  (r_addr),
        .r_data_reg  (rd_a),
        .r_valid_reg (rv_a),
        .w_ctrl_reg  (w_ctrl),
        .w_addr_reg  (w_addr),
        .w_data_reg  (w_data),
        .iss_ctrl    (iss_ctrl),
        .iss_addr    (iss_addr),
        .busy_vec    (busy_a)
    );

    regfile_sb #(
        .BYPASS_EN   (1'b0),
        .ZERO_REG_EN (1'b0)
    ) u_nb (
        .clk         (clk),
        .rst         (rst),
        .r_addr_reg  (r_addr),
        .r_data_reg  (rd_b),
        .r_valid_reg (rv_b),
        .w_ctrl_reg  (w_ctrl),
        .w_addr_reg  (w_addr),
        .w_data_reg  (w_data),
        .iss_ctrl    (iss_ctrl),
        .iss_addr    (iss_addr),
        .busy_vec    (busy_b)
    );

    task automatic idle();
        w_ctrl   = 1'b0;
        w_addr   = '0;
        w_data   = '0;
        iss_ctrl = 1'b0;
        iss_addr = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        r_addr = {a1, a0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        set_rd(5'd0, 5'd0);
        #1 rst = 1'b0;
        r_addr   = NR*AW'($urandom_range(1023, 33));
        w_ctrl   = 1'b1;
        w_addr   = r_addr[AW-1:0];
        w_data   = $urandom;
        iss_ctrl = 1'b1;
        iss_addr = AW'($urandom_range(31, 1));
        #2;
        n_tests++;
        if ({rd_a, rd_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h, want 0", rd_a, rd_b);
        end
        n_tests++;
        if ({rv_a, rv_b} !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_valid: got %b %b, want 11 11", rv_a, rv_b);
        end
        repeat (2) tick();
        n_tests++;
        if ({busy_a, busy_b} !== '0 || {rd_a, rd_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_held: busy %h %h data %h %h, want all 0", busy_a, busy_b, rd_a, rd_b);
        end
        idle();
        @(negedge clk);
        rst = 1'b1;
        for (int a = 1; a < 32; a++) begin
            set_rd(AW'(a), AW'(32 - a));
            #1;
            n_tests++;
            if ({rd_a, rd_b} !== '0 || {rv_a, rv_b} !== 4'b1111) begin
                n_fail++;
                $display("FAIL post_reset_read_%0d: got %h %h valid %b %b, want 0 valid 1111", a, rd_a, rd_b, rv_a, rv_b);
            end
        end
    endtask

    task automatic test_write_read();
        w_ctrl = 1'b1; w_addr = 5'd8; w_data = 32'd3;
        set_rd(5'd9, 5'd0);
        tick();
        idle();
        set_rd(5'd8, 5'd0);
        #1;
        n_tests++;
        if (rd_a[0 +: DL] !== 32'd3 || rv_a[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_rd_p0: got %h valid %b, want 00000003 valid 1", rd_a[0 +: DL], rv_a[0]);
        end
        n_tests++;
        if (rd_a[DL +: DL] !== 32'd0) begin
            n_fail++;
            $display("FAIL wr_rd_p1_x0: got %h, want 0", rd_a[DL +: DL]);
        end
        n_tests++;
        if (rd_b[0 +: DL] !== 32'd3) begin
            n_fail++;
            $display("FAIL wr_rd_nb: got %h, want 00000003", rd_b[0 +: DL]);
        end
    endtask

    task automatic test_bypass();
        w_ctrl = 1'b1; w_addr = 5'd5; w_data = 32'hDEADBEEF;
        set_rd(5'd5, 5'd5);
        #1;
        n_tests++;
        if (rd_a !== {32'hDEADBEEF, 32'hDEADBEEF} || rv_a !== 2'b11) begin
            n_fail++;
            $display("FAIL bypass_both_ports: got %h valid %b, want deadbeefdeadbeef valid 11", rd_a, rv_a);
        end
        n_tests++;
        if (rd_b[DL +: DL] !== 32'd0 || rv_b[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL nobypass_old: got %h valid %b, want 0 valid 1", rd_b[DL +: DL], rv_b[1]);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if (rd_b[DL +: DL] !== 32'hDEADBEEF || rd_a[DL +: DL] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: got %h %h, want deadbeef", rd_a[DL +: DL], rd_b[DL +: DL]);
        end
    endtask

    task automatic test_scoreboard();
        iss_ctrl = 1'b1; iss_addr = 5'd12;
        set_rd(5'd12, 5'd5);
        #1;
        n_tests++;
        if (rv_a[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_same_cycle_valid: got %b, want 1", rv_a[0]);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if (busy_a !== 32'h0000_1000 || rv_a !== 2'b10) begin
            n_fail++;
            $display("FAIL issue_busy: busy %h valid %b, want 00001000 valid 10", busy_a, rv_a);
        end
        w_ctrl = 1'b1; w_addr = 5'd12; w_data = 32'h55;
        #1;
        n_tests++;
        if (rd_a[0 +: DL] !== 32'h55 || rv_a[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL wb_bypass: got %h valid %b, want 00000055 valid 1", rd_a[0 +: DL], rv_a[0]);
        end
        n_tests++;
        if (rd_b[0 +: DL] !== 32'd0 || rv_b[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_nobypass: got %h valid %b, want 0 valid 0", rd_b[0 +: DL], rv_b[0]);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if (busy_a !== 32'd0 || busy_b !== 32'd0 || rd_b[0 +: DL] !== 32'h55 || rv_a !== 2'b11) begin
            n_fail++;
            $display("FAIL wb_clear: busy %h %h data %h valid %b, want 0 0 00000055 11", busy_a, busy_b, rd_b[0 +: DL], rv_a);
        end
    endtask

    task automatic test_collision();
        iss_ctrl = 1'b1; iss_addr = 5'd7;
        w_ctrl = 1'b1; w_addr = 5'd7; w_data = 32'hA5;
        set_rd(5'd7, 5'd7);
        tick();
        idle();
        #1;
        n_tests++;
        if (rd_a[0 +: DL] !== 32'hA5 || rv_a !== 2'b00) begin
            n_fail++;
            $display("FAIL collision_read: got %h valid %b, want 000000a5 valid 00", rd_a[0 +: DL], rv_a);
        end
        n_tests++;
        if (busy_a !== 32'h80 || busy_b !== 32'h80) begin
            n_fail++;
            $display("FAIL collision_busy: got %h %h, want 00000080", busy_a, busy_b);
        end
        w_ctrl = 1'b1; w_addr = 5'd7; w_data = 32'hA5;
        tick();
        idle();
        #1;
        n_tests++;
        if (busy_a !== 32'd0) begin
            n_fail++;
            $display("FAIL collision_retire: got %h, want 0", busy_a);
        end
    endtask

    task automatic test_zero();
        w_ctrl = 1'b1; w_addr = 5'd0; w_data = 32'hFFFF;
        iss_ctrl = 1'b1; iss_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        #1;
        n_tests++;
        if (rd_a[0 +: DL] !== 32'd0 || rv_a !== 2'b11) begin
            n_fail++;
            $display("FAIL x0_no_bypass: got %h valid %b, want 0 valid 11", rd_a[0 +: DL], rv_a);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if (rd_a !== '0 || rv_a !== 2'b11 || busy_a !== 32'd0) begin
            n_fail++;
            $display("FAIL x0_hardwired: data %h valid %b busy %h, want 0 11 0", rd_a, rv_a, busy_a);
        end
        n_tests++;
        if (rd_b[0 +: DL] !== 32'hFFFF || rv_b !== 2'b00 || busy_b !== 32'd1) begin
            n_fail++;
            $display("FAIL x0_ordinary: data %h valid %b busy %h, want 0000ffff 00 00000001", rd_b[0 +: DL], rv_b, busy_b);
        end
        w_ctrl = 1'b1; w_addr = 5'd0; w_data = 32'd0;
        tick();
        idle();
        #1;
        n_tests++;
        if (busy_b !== 32'd0) begin
            n_fail++;
            $display("FAIL x0_ordinary_retire: got %h, want 0", busy_b);
        end
    endtask

    task automatic test_back_to_back();
        w_ctrl = 1'b1; w_addr = 5'd20; w_data = 32'd1;
        tick();
        w_addr = 5'd21; w_data = 32'd2;
        set_rd(5'd20, 5'd21);
        #1;
        n_tests++;
        if (rd_a !== {32'd2, 32'd1}) begin
            n_fail++;
            $display("FAIL b2b_bypass: got %h, want 0000000200000001", rd_a);
        end
        n_tests++;
        if (rd_b !== {32'd0, 32'd1}) begin
            n_fail++;
            $display("FAIL b2b_nobypass: got %h, want 0000000000000001", rd_b);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if (rd_b !== {32'd2, 32'd1}) begin
            n_fail++;
            $display("FAIL b2b_settled: got %h, want 0000000200000001", rd_b);
        end
    endtask

    task automatic test_midop_reset();
        iss_ctrl = 1'b1; iss_addr = 5'd3;
        set_rd(5'd8, 5'd5);
        tick();
        idle();
        #1;
        n_tests++;
        if (busy_a !== 32'h8) begin
            n_fail++;
            $display("FAIL midop_busy_before: got %h, want 00000008", busy_a);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (busy_a !== 32'd0 || busy_b !== 32'd0) begin
            n_fail++;
            $display("FAIL midop_busy_async: got %h %h, want 0", busy_a, busy_b);
        end
        n_tests++;
        if ({rd_a, rd_b} !== '0 || {rv_a, rv_b} !== 4'b1111) begin
            n_fail++;
            $display("FAIL midop_outputs: data %h %h valid %b %b, want 0 1111", rd_a, rd_b, rv_a, rv_b);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({rd_a, rd_b} !== '0 || {rv_a, rv_b} !== 4'b1111) begin
            n_fail++;
            $display("FAIL midop_mem_cleared: data %h %h valid %b %b, want 0 1111", rd_a, rd_b, rv_a, rv_b);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_zero();
        test_back_to_back();
        test_midop_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
